spi_rd_word_packer: RTL

- Downstream stage of the SPI flash read engine.
- Accepts the byte stream read from flash and packs it little-endian into 32-bit words.
- Buffers the words in an internal FIFO and presents them on a ready/valid word interface to the image-copy consumer.
- Tracks byte count and end of image, and applies backpressure to the reader through pause_req.

---
 rtl/spi_rd_pkg.sv | 42 ++++
 rtl/spi_rd_word_packer_if.sv | 28 ++
 rtl/spi_rd_word_fifo.sv | 65 ++++++
 rtl/spi_rd_word_packer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/spi_rd_pkg.sv
// Shared definitions for the SPI flash read word packer: FSM encoding,
// byte-enable constants, default FIFO sizing and lane-mask helpers.
package spi_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PACK  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] KEEP_FULL = 4'hF;
   localparam logic [3:0] KEEP_NONE = 4'h0;

   localparam int DEF_FIFO_DEPTH      = 16;
   localparam int DEF_ALMOST_FULL_LVL = 12;

   // FIFO entry layout: {last, keep[3:0], data[31:0]}
   localparam int WORD_W = 37;

   // Byte-enable mask for a partial word holding n bytes (n = 0 gives none).
   function automatic logic [3:0] keep_mask(input logic [1:0] n);
      logic [3:0] m;
      case (n)
         2'd0:    m = KEEP_NONE;
         2'd1:    m = 4'b0001;
         2'd2:    m = 4'b0011;
         default: m = 4'b0111;
      endcase
      return m;
   endfunction

   // Expand a byte-enable mask to a 32-bit lane mask.
   function automatic logic [31:0] lane_mask(input logic [3:0] keep);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) begin
         m[i*8 +: 8] = {8{keep[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/spi_rd_word_packer_if.sv
// Byte-stream input and word-stream output of the packer.
// Word side: a word transfers on a cycle where word_valid && word_ready are
// both high; while word_valid is high and word_ready low, word_data,
// word_keep and word_last are held. The byte side has no ready: the reader
// is throttled through pause_req instead.
interface spi_rd_word_packer_if;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        read_finish;
   logic        pause_req;
   logic        word_valid;
   logic        word_ready;
   logic [31:0] word_data;
   logic [3:0]  word_keep;
   logic        word_last;

   // Packer side: consumes bytes, produces words.
   modport master (
      input  byte_valid, byte_data, read_finish, word_ready,
      output pause_req, word_valid, word_data, word_keep, word_last
   );

   // Environment side: reader and image-copy consumer.
   modport slave (
      output byte_valid, byte_data, read_finish, word_ready,
      input  pause_req, word_valid, word_data, word_keep, word_last
   );
endinterface

// File: rtl/spi_rd_word_fifo.sv
// Synchronous first-word-fall-through FIFO with clear and fill count.
// A push while full is accepted only if a pop frees a slot the same cycle.
module spi_rd_word_fifo
   import spi_rd_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH,
   parameter int WIDTH = WORD_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   fill
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == DEPTH_C);
   assign fill     = count;
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   // Storage array; no reset needed, contents are qualified by count.
   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/spi_rd_word_packer.sv
// Packs the flash read byte stream little-endian into 32-bit words, buffers
// them in a FWFT FIFO and tracks byte count, end of image and overflow.
// Optional build macro PACKER_CHECKSUM_EN adds a running byte checksum;
// without it the checksum port is tied to zero.
module spi_rd_word_packer
   import spi_rd_pkg::*;
#(
   parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
   parameter int ALMOST_FULL_LVL = DEF_ALMOST_FULL_LVL
) (
   input  logic                        system_clk,
   input  logic                        system_reset_n,
   input  logic                        start_flag,
   spi_rd_word_packer_if.master        bus,
   output logic [31:0]                 byte_count,
   output logic                        overflow,
   output logic                        done,
   output logic [31:0]                 checksum,
   output state_t                      fsm_state
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] AF_LVL = CW'(ALMOST_FULL_LVL);

   state_t            state;
   state_t            state_nxt;
   logic [31:0]       pack_reg;
   logic [1:0]        byte_idx;
   logic              accept;
   logic              push_req;
   logic [WORD_W-1:0] push_word;
   logic [WORD_W-1:0] fifo_dout;
   logic              fifo_empty;
   logic              fifo_full;
   logic [CW-1:0]     fifo_fill;
   logic              drop;
   logic              pause_q;

   assign fsm_state = state;
   assign accept    = (state == PACK) && bus.byte_valid && !start_flag;
   assign drop      = push_req && fifo_full && !bus.word_ready;

   assign bus.word_valid = !fifo_empty;
   assign bus.pause_req  = pause_q;
   assign {bus.word_last, bus.word_keep, bus.word_data} = fifo_dout;

   // State register.
   always_ff @(posedge system_clk or negedge system_reset_n) begin
      if (!system_reset_n) state <= IDLE;
      else                 state <= state_nxt;
   end

   // Next state and word push requests; start_flag overrides everything.
   always_comb begin
      state_nxt = state;
      push_req  = 1'b0;
      push_word = '0;
      if (start_flag) begin
         state_nxt = PACK;
      end else begin
         case (state)
            IDLE: ;
            PACK: begin
               if (bus.byte_valid && byte_idx == 2'd3) begin
                  push_req  = 1'b1;
                  push_word = {1'b0, KEEP_FULL, bus.byte_data, pack_reg[23:0]};
               end
               if (bus.read_finish) state_nxt = FLUSH;
            end
            FLUSH: begin
               // Residual bytes form a partial word; none gives a marker.
               push_req  = 1'b1;
               push_word = {1'b1, keep_mask(byte_idx),
                            pack_reg & lane_mask(keep_mask(byte_idx))};
               state_nxt = DONE;
            end
            DONE: ;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Packing datapath, counters, sticky flags and registered backpressure.
   always_ff @(posedge system_clk or negedge system_reset_n) begin
      if (!system_reset_n) begin
         pack_reg   <= '0;
         byte_idx   <= '0;
         byte_count <= '0;
         overflow   <= 1'b0;
         done       <= 1'b0;
         pause_q    <= 1'b0;
      end else if (start_flag) begin
         pack_reg   <= '0;
         byte_idx   <= '0;
         byte_count <= '0;
         overflow   <= 1'b0;
         done       <= 1'b0;
         pause_q    <= 1'b0;
      end else begin
         if (accept) begin
            pack_reg[{byte_idx, 3'b000} +: 8] <= bus.byte_data;
            byte_idx   <= byte_idx + 1'b1;
            byte_count <= byte_count + 32'd1;
         end
         if (state == FLUSH) begin
            pack_reg <= '0;
            byte_idx <= '0;
         end
         if (drop) overflow <= 1'b1;
         if (state == DONE && bus.word_valid && bus.word_ready && bus.word_last)
            done <= 1'b1;
         pause_q <= (fifo_fill >= AF_LVL);
      end
   end

`ifdef PACKER_CHECKSUM_EN
   // Wrapping sum of accepted bytes; only PACK accepts, so DONE freezes it.
   always_ff @(posedge system_clk or negedge system_reset_n) begin
      if (!system_reset_n)  checksum <= '0;
      else if (start_flag)  checksum <= '0;
      else if (accept)      checksum <= checksum + {24'd0, bus.byte_data};
   end
`else
   assign checksum = '0;
`endif

   spi_rd_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk       (system_clk),
      .rst_n     (system_reset_n),
      .clear     (start_flag),
      .push      (push_req),
      .push_data (push_word),
      .pop       (bus.word_ready),
      .pop_data  (fifo_dout),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .fill      (fifo_fill)
   );
endmodule
